gemm_tile_seq: RTL and testbench
================================

# gemm_tile_seq

Sequencer that drives `mac_array_2x2` as its initiator, computing one 2x2 output tile C = A·B over a K-deep reduction. It accepts a job (depth K), pulls one K-slice of operands per beat from an upstream stream, issues each slice to the array with the running partial sums as `acc*`, and captures the array's `y*` back into its partial-sum registers. After the last slice it presents the final tile on a valid/ready result port. It replaces the hand-sequenced partial-sum feedback currently done in benches.

## Interface
- `KMAX`, 16: maximum reduction depth; sets `job_k` width to $clog2(KMAX+1).
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `job_valid` in 1; `job_ready` out 1; `job_k` in $clog2(KMAX+1): job handshake; K = 0..KMAX.
- `slice_valid` in 1; `slice_ready` out 1: operand-slice handshake.
- `slice_a0`, `slice_a1`, `slice_b0`, `slice_b1` in 8 signed: A[0][k], A[1][k], B[k][0], B[k][1].
- `arr_in_valid` out 1; `arr_a0`, `arr_a1`, `arr_b0`, `arr_b1` out 8 signed: to array.
- `arr_acc00`, `arr_acc01`, `arr_acc10`, `arr_acc11` out 32 signed: partial sums to array.
- `arr_out_valid` in 1; `arr_y00`, `arr_y01`, `arr_y10`, `arr_y11` in 32 signed: from array.
- `res_valid` out 1; `res_ready` in 1; `res_y00`, `res_y01`, `res_y10`, `res_y11` out 32 signed: final tile.

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: `job_ready`=1. On `job_valid && job_ready`: latch K, clear k_cnt and partials p00..p11 to 0; go FETCH if K>0, else DONE (zero tile).
- FETCH: `slice_ready`=1. On `slice_valid`: register the four operands, go ISSUE.
- ISSUE: `arr_in_valid`=1 for exactly one cycle; `arr_a*/b*` = registered operands; `arr_acc*` = p**. Go WAIT.
- WAIT: on `arr_out_valid`: p** <= `arr_y**`; if k_cnt == K-1 go DONE, else k_cnt++ and go FETCH.
- DONE: `res_valid`=1, `res_y**` = p**, held stable until `res_ready`; on handshake go IDLE.
- Array latency is not assumed; WAIT persists any number of cycles.
- `arr_out_valid` outside WAIT is ignored (no state or partial change).
- Arithmetic: 32-bit two's complement, wraps modulo 2^32 (the array performs the add; sequencer only stores).
- `job_k` > KMAX: saturated to KMAX.

## Timing
- Reset: all outputs 0 (`job_ready`, `slice_ready`, `arr_in_valid`, `res_valid`, all data); state IDLE; partials 0. `job_ready` rises the cycle after `rst` deasserts.
- Reset mid-job from any state: IDLE next cycle, job discarded; a late `arr_out_valid` from the aborted issue is ignored.
- Per slice: FETCH handshake cycle -> ISSUE next cycle -> WAIT for array latency L. With `slice_valid` held high and L=1: 3 cycles/slice.
- Job latency (continuous slices, L=1, res_ready=1): 1 (accept) + 3K + 1 (DONE) cycles.
- `arr_a*/b*/acc*` are 0 whenever `arr_in_valid`=0.
- `res_y**` do not change while `res_valid`=1 and `res_ready`=0.
- No overlap: next job is accepted only after the result handshake.

## Structure
- Shared package `gemm_pkg`: `OP_W`=8, `ACC_W`=32, `typedef logic signed [OP_W-1:0] op_t`, `typedef logic signed [ACC_W-1:0] acc_t`, FSM state enum `seq_state_e`.
- Single module; no sub-module. Bench instantiates it with `mac_array_2x2` as DUT pair.

## Test plan
- K=2, slices (a0,a1,b0,b1) = (1,3,5,6) then (2,4,7,8) -> result {19,22;43,50}; `arr_acc**` on second issue = {5,6;15,18}.
- K=1, slice (-3,7,4,-2) -> result {-12,6;28,-14}.
- K=0 -> `res_valid` cycle after accept, tile {0,0;0,0}; `slice_ready` never asserted.
- K=16, all slices (-128,-128,-128,-128) with random `slice_valid` gaps -> every entry 262144; exactly 16 `arr_in_valid` pulses.
- Same K=2 job, `res_ready` low 5 cycles -> `res_valid` and values held; `job_ready` stays 0 until handshake.
- `rst` pulsed while in WAIT, then inject `arr_out_valid` -> stays IDLE, outputs 0; following K=2 job gives {19,22;43,50}.

Source files
------------

// File: rtl/gemm_tile_seq_pkg.sv
// Shared types for the 2x2 GEMM tile sequencer: operand/accumulator widths
// and the sequencer FSM state encoding.
package gemm_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 32;

  typedef logic signed [OP_W-1:0]  op_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/gemm_tile_seq_if.sv
// Bundle of the job, operand-slice, array and result channels of the tile
// sequencer. The slave modport is the sequencer; master is its environment.
interface gemm_tile_seq_if #(
  parameter int KMAX = 16
) ();
  import gemm_pkg::*;

  localparam int KW = $clog2(KMAX + 1);

  // Every channel is valid/ready: a transfer happens on a rising clk edge
  // where both are high; the sender holds payload stable until then.
  logic          job_valid;
  logic          job_ready;
  logic [KW-1:0] job_k;

  logic          slice_valid;
  logic          slice_ready;
  op_t           slice_a0;
  op_t           slice_a1;
  op_t           slice_b0;
  op_t           slice_b1;

  logic          arr_in_valid;
  op_t           arr_a0;
  op_t           arr_a1;
  op_t           arr_b0;
  op_t           arr_b1;
  acc_t          arr_acc00;
  acc_t          arr_acc01;
  acc_t          arr_acc10;
  acc_t          arr_acc11;

  logic          arr_out_valid;
  acc_t          arr_y00;
  acc_t          arr_y01;
  acc_t          arr_y10;
  acc_t          arr_y11;

  logic          res_valid;
  logic          res_ready;
  acc_t          res_y00;
  acc_t          res_y01;
  acc_t          res_y10;
  acc_t          res_y11;

  modport slave (
    input  job_valid, job_k,
    output job_ready,
    input  slice_valid, slice_a0, slice_a1, slice_b0, slice_b1,
    output slice_ready,
    output arr_in_valid, arr_a0, arr_a1, arr_b0, arr_b1,
    output arr_acc00, arr_acc01, arr_acc10, arr_acc11,
    input  arr_out_valid, arr_y00, arr_y01, arr_y10, arr_y11,
    output res_valid, res_y00, res_y01, res_y10, res_y11,
    input  res_ready
  );

  modport master (
    output job_valid, job_k,
    input  job_ready,
    output slice_valid, slice_a0, slice_a1, slice_b0, slice_b1,
    input  slice_ready,
    input  arr_in_valid, arr_a0, arr_a1, arr_b0, arr_b1,
    input  arr_acc00, arr_acc01, arr_acc10, arr_acc11,
    output arr_out_valid, arr_y00, arr_y01, arr_y10, arr_y11,
    input  res_valid, res_y00, res_y01, res_y10, res_y11,
    output res_ready
  );

endinterface

// File: rtl/gemm_tile_seq.sv
// Drives a 2x2 MAC array through a K-deep reduction, feeding back the array's
// outputs as the next slice's partial sums, and returns the finished tile.
module gemm_tile_seq
  import gemm_pkg::*;
#(
  parameter int KMAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  gemm_tile_seq_if.slave bus,
  output seq_state_e     state_o
);

  localparam int            KW    = $clog2(KMAX + 1);
  localparam logic [KW-1:0] K_MAX = KW'(KMAX);

  seq_state_e    state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;
  logic [KW-1:0] kcnt_q;
  logic          last_slice;

  logic          job_ready_q;
  logic          slice_ready_q;
  logic          arr_in_valid_q;
  logic          res_valid_q;

  op_t           a0_q;
  op_t           a1_q;
  op_t           b0_q;
  op_t           b1_q;

  acc_t          p00_q;
  acc_t          p01_q;
  acc_t          p10_q;
  acc_t          p11_q;

  always_comb begin
    k_d = bus.job_k;
    if (bus.job_k > K_MAX) begin
      k_d = K_MAX;
    end
  end

  assign last_slice = (kcnt_q == (k_q - KW'(1)));

  // Handshake flags are registered alongside the state so every output is
  // low in reset and job_ready only rises once reset has been released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      kcnt_q         <= '0;
      job_ready_q    <= 1'b0;
      slice_ready_q  <= 1'b0;
      arr_in_valid_q <= 1'b0;
      res_valid_q    <= 1'b0;
      a0_q           <= '0;
      a1_q           <= '0;
      b0_q           <= '0;
      b1_q           <= '0;
      p00_q          <= '0;
      p01_q          <= '0;
      p10_q          <= '0;
      p11_q          <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          job_ready_q <= 1'b1;
          if (job_ready_q && bus.job_valid) begin
            job_ready_q <= 1'b0;
            k_q         <= k_d;
            kcnt_q      <= '0;
            p00_q       <= '0;
            p01_q       <= '0;
            p10_q       <= '0;
            p11_q       <= '0;
            if (k_d == '0) begin
              state_q     <= ST_DONE;
              res_valid_q <= 1'b1;
            end else begin
              state_q       <= ST_FETCH;
              slice_ready_q <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (bus.slice_valid) begin
            a0_q           <= bus.slice_a0;
            a1_q           <= bus.slice_a1;
            b0_q           <= bus.slice_b0;
            b1_q           <= bus.slice_b1;
            slice_ready_q  <= 1'b0;
            arr_in_valid_q <= 1'b1;
            state_q        <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          arr_in_valid_q <= 1'b0;
          state_q        <= ST_WAIT;
        end

        // Array latency is open-ended; only a response seen here is taken.
        ST_WAIT: begin
          if (bus.arr_out_valid) begin
            p00_q <= bus.arr_y00;
            p01_q <= bus.arr_y01;
            p10_q <= bus.arr_y10;
            p11_q <= bus.arr_y11;
            if (last_slice) begin
              state_q     <= ST_DONE;
              res_valid_q <= 1'b1;
            end else begin
              kcnt_q        <= kcnt_q + KW'(1);
              state_q       <= ST_FETCH;
              slice_ready_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q        <= ST_IDLE;
          job_ready_q    <= 1'b0;
          slice_ready_q  <= 1'b0;
          arr_in_valid_q <= 1'b0;
          res_valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.job_ready    = job_ready_q;
  assign bus.slice_ready  = slice_ready_q;
  assign bus.arr_in_valid = arr_in_valid_q;
  assign bus.res_valid    = res_valid_q;

  // Array-side buses read as zero whenever no slice is being issued.
  assign bus.arr_a0    = arr_in_valid_q ? a0_q  : '0;
  assign bus.arr_a1    = arr_in_valid_q ? a1_q  : '0;
  assign bus.arr_b0    = arr_in_valid_q ? b0_q  : '0;
  assign bus.arr_b1    = arr_in_valid_q ? b1_q  : '0;
  assign bus.arr_acc00 = arr_in_valid_q ? p00_q : '0;
  assign bus.arr_acc01 = arr_in_valid_q ? p01_q : '0;
  assign bus.arr_acc10 = arr_in_valid_q ? p10_q : '0;
  assign bus.arr_acc11 = arr_in_valid_q ? p11_q : '0;

  assign bus.res_y00 = res_valid_q ? p00_q : '0;
  assign bus.res_y01 = res_valid_q ? p01_q : '0;
  assign bus.res_y10 = res_valid_q ? p10_q : '0;
  assign bus.res_y11 = res_valid_q ? p11_q : '0;

  assign state_o = state_q;

endmodule

// File: tb/tb_gemm_tile_seq.sv
// Bench for gemm_tile_seq with a behavioural 2x2 MAC array of adjustable
// latency; results are scored against an expected-tile queue.
module tb_gemm_tile_seq;
  import gemm_pkg::*;

  localparam int KMAX = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_e state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gemm_tile_seq_if #(.KMAX(KMAX)) bus ();

  gemm_tile_seq #(.KMAX(KMAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  int           checks   = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] acc_log[$];
  logic [31:0]  slice_mem[32];

  typedef struct packed {
    logic [4:0]   k;
    logic [31:0]  s0;
    logic [31:0]  s1;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1, input int b0, input int b1);
    return {a0[7:0], a1[7:0], b0[7:0], b1[7:0]};
  endfunction

  function automatic logic [127:0] tl(input int y00, input int y01, input int y10, input int y11);
    return {y00, y01, y10, y11};
  endfunction

  function automatic vec_t mk(input int k, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [127:0] e);
    vec_t v;
    v.k   = 5'(k);
    v.s0  = s0;
    v.s1  = s1;
    v.exp = e;
    return v;
  endfunction

  // Reference tile: plain sum of outer products over the slices in slice_mem.
  function automatic logic [127:0] tile_ref(input int n);
    acc_t y00 = 0, y01 = 0, y10 = 0, y11 = 0;
    op_t  a0, a1, b0, b1;
    for (int i = 0; i < n; i++) begin
      {a0, a1, b0, b1} = slice_mem[i];
      y00 = y00 + acc_t'(a0) * acc_t'(b0);
      y01 = y01 + acc_t'(a0) * acc_t'(b1);
      y10 = y10 + acc_t'(a1) * acc_t'(b0);
      y11 = y11 + acc_t'(a1) * acc_t'(b1);
    end
    return {y00, y01, y10, y11};
  endfunction

  // ---------------- MAC array model and bus monitor ----------------
  int           arr_lat   = 1;
  int           arr_cnt   = 0;
  int           stray_req = 0;
  int           stray_ack = 0;
  int           pulses    = 0;
  int           idle_viol = 0;
  int           sready_cyc = 0;
  logic [127:0] arr_pend;
  acc_t         m00, m01, m10, m11;

  always @(negedge clk) begin
    bus.arr_out_valid = 1'b0;
    {bus.arr_y00, bus.arr_y01, bus.arr_y10, bus.arr_y11} = '0;
    if (arr_cnt > 0) begin
      arr_cnt--;
      if (arr_cnt == 0) begin
        bus.arr_out_valid = 1'b1;
        {bus.arr_y00, bus.arr_y01, bus.arr_y10, bus.arr_y11} = arr_pend;
      end
    end
    if (stray_req != stray_ack) begin
      stray_ack         = stray_req;
      bus.arr_out_valid = 1'b1;
      {bus.arr_y00, bus.arr_y01, bus.arr_y10, bus.arr_y11} = {4{32'h5a5a_0101}};
    end
    if (bus.arr_in_valid === 1'b1) begin
      pulses++;
      acc_log.push_back({bus.arr_acc00, bus.arr_acc01, bus.arr_acc10, bus.arr_acc11});
      m00 = bus.arr_acc00 + acc_t'(bus.arr_a0) * acc_t'(bus.arr_b0);
      m01 = bus.arr_acc01 + acc_t'(bus.arr_a0) * acc_t'(bus.arr_b1);
      m10 = bus.arr_acc10 + acc_t'(bus.arr_a1) * acc_t'(bus.arr_b0);
      m11 = bus.arr_acc11 + acc_t'(bus.arr_a1) * acc_t'(bus.arr_b1);
      arr_pend = {m00, m01, m10, m11};
      arr_cnt  = arr_lat;
    end else if ({bus.arr_a0, bus.arr_a1, bus.arr_b0, bus.arr_b1, bus.arr_acc00,
                  bus.arr_acc01, bus.arr_acc10, bus.arr_acc11} !== '0) begin
      idle_viol++;
    end
    if (bus.slice_ready === 1'b1) sready_cyc++;
  end

  // ---------------- driver ----------------
  task automatic run_job(input logic [4:0] k_in, input int nsl, input logic [127:0] exp,
                         input bit gaps, input int hold, input int lat_exp);
    int           t;
    int           a_cyc;
    int           d_cyc;
    logic [127:0] snap;
    exp_q.push_back(exp);

    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_k     = k_in;
    t = 0;
    while (!bus.job_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("job_accept");
    a_cyc = cyc;
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.job_k     = '0;

    for (int i = 0; i < nsl; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.slice_valid = 1'b1;
      {bus.slice_a0, bus.slice_a1, bus.slice_b0, bus.slice_b1} = slice_mem[i];
      t = 0;
      while (!bus.slice_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) timeout("slice_accept");
      @(negedge clk);
      if (gaps || i == nsl - 1) begin
        bus.slice_valid = 1'b0;
        {bus.slice_a0, bus.slice_a1, bus.slice_b0, bus.slice_b1} = '0;
      end
    end

    t = 0;
    while (!bus.res_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("res_valid_wait");
    d_cyc = cyc;
    if (lat_exp >= 0) chk("job_latency", 128'(d_cyc - a_cyc), 128'(lat_exp));

    snap = {bus.res_y00, bus.res_y01, bus.res_y10, bus.res_y11};
    for (int h = 0; h < hold; h++) begin
      chk("hold_res_valid", 128'(bus.res_valid), 128'(1));
      chk("hold_res_data", {bus.res_y00, bus.res_y01, bus.res_y10, bus.res_y11}, snap);
      chk("hold_job_ready", 128'(bus.job_ready), 128'(0));
      @(negedge clk);
    end

    bus.res_ready = 1'b1;
    chk("res_tile", {bus.res_y00, bus.res_y01, bus.res_y10, bus.res_y11}, exp_q.pop_front());
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("job_ready_after_result", 128'(bus.job_ready), 128'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    int s0;
    int t;
    int late;
    int bad;
    int k;

    bus.job_valid   = 1'b0;
    bus.job_k       = '0;
    bus.slice_valid = 1'b0;
    {bus.slice_a0, bus.slice_a1, bus.slice_b0, bus.slice_b1} = '0;
    bus.res_ready   = 1'b0;

    vecs[0] = mk(2, pk(1, 3, 5, 6), pk(2, 4, 7, 8), tl(19, 22, 43, 50));
    vecs[1] = mk(1, pk(-3, 7, 4, -2), 32'd0, tl(-12, 6, 28, -14));
    vecs[2] = mk(0, 32'd0, 32'd0, tl(0, 0, 0, 0));
    vecs[3] = mk(2, pk(127, -128, 127, -128), pk(-128, -128, -128, -128),
                 tl(32513, 128, 128, 32768));
    vecs[4] = mk(1, pk(0, 5, -1, 9), 32'd0, tl(0, 0, -5, 45));

    repeat (3) @(negedge clk);
    chk("rst_job_ready", 128'(bus.job_ready), 128'(0));
    chk("rst_slice_ready", 128'(bus.slice_ready), 128'(0));
    chk("rst_arr_in_valid", 128'(bus.arr_in_valid), 128'(0));
    chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
    chk("rst_res_data", {bus.res_y00, bus.res_y01, bus.res_y10, bus.res_y11}, '0);
    chk("rst_state", 128'(state), 128'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("job_ready_rise", 128'(bus.job_ready), 128'(1));

    // table of short jobs, continuous slices, L=1
    for (int v = 0; v < 5; v++) begin
      slice_mem[0] = vecs[v].s0;
      slice_mem[1] = vecs[v].s1;
      acc_log.delete();
      p0 = pulses;
      s0 = sready_cyc;
      run_job(vecs[v].k, int'(vecs[v].k), vecs[v].exp, 1'b0, 0, 3 * int'(vecs[v].k) + 1);
      chk("issue_pulses", 128'(pulses - p0), 128'(vecs[v].k));
      if (vecs[v].k == 5'd0) chk("k0_no_slice_ready", 128'(sready_cyc - s0), 128'(0));
      if (v == 0) begin
        chk("acc_log_size", 128'(acc_log.size()), 128'(2));
        if (acc_log.size() >= 2) begin
          chk("first_issue_acc", acc_log[0], '0);
          chk("second_issue_acc", acc_log[1], tl(5, 6, 15, 18));
        end
      end
    end

    // result back-pressure: res_ready held low 5 cycles
    slice_mem[0] = vecs[0].s0;
    slice_mem[1] = vecs[0].s1;
    run_job(5'd2, 2, tl(19, 22, 43, 50), 1'b0, 5, 7);

    // K=16 of the most negative operands, slices arrive with random gaps
    for (int i = 0; i < 16; i++) slice_mem[i] = 32'h8080_8080;
    p0 = pulses;
    run_job(5'd16, 16, tl(262144, 262144, 262144, 262144), 1'b1, 0, -1);
    chk("k16_issue_pulses", 128'(pulses - p0), 128'(16));

    // job_k above KMAX runs as KMAX slices
    for (int i = 0; i < 16; i++) slice_mem[i] = $urandom();
    p0 = pulses;
    run_job(5'd20, 16, tile_ref(16), 1'b0, 0, 49);
    chk("sat_issue_pulses", 128'(pulses - p0), 128'(16));

    // random jobs, some with a slower array
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) slice_mem[i] = $urandom();
      arr_lat = (r >= 2) ? 3 : 1;
      run_job(5'(k), k, tile_ref(k), r[0], $urandom_range(0, 2), -1);
    end
    arr_lat = 1;

    // reset while waiting on the array; the late response must be ignored
    arr_lat = 4;
    slice_mem[0] = vecs[0].s0;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_k     = 5'd2;
    t = 0;
    while (!bus.job_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("abort_job_accept");
    @(negedge clk);
    bus.job_valid   = 1'b0;
    bus.job_k       = '0;
    bus.slice_valid = 1'b1;
    {bus.slice_a0, bus.slice_a1, bus.slice_b0, bus.slice_b1} = slice_mem[0];
    t = 0;
    while (!bus.slice_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("abort_slice_accept");
    @(negedge clk);
    bus.slice_valid = 1'b0;
    {bus.slice_a0, bus.slice_a1, bus.slice_b0, bus.slice_b1} = '0;
    t = 0;
    while (state != ST_WAIT && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout("abort_reach_wait");
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    late = 0;
    bad  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 5) stray_req++;
      if (bus.arr_out_valid) late++;
      if (state != ST_IDLE || bus.slice_ready || bus.arr_in_valid || bus.res_valid ||
          {bus.res_y00, bus.res_y01, bus.res_y10, bus.res_y11} != '0) bad++;
    end
    chk("late_arr_valid_seen", 128'(late >= 2), 128'(1));
    chk("abort_stays_idle", 128'(bad), 128'(0));
    chk("abort_job_ready", 128'(bus.job_ready), 128'(1));
    arr_lat = 1;
    slice_mem[0] = vecs[0].s0;
    slice_mem[1] = vecs[0].s1;
    run_job(5'd2, 2, tl(19, 22, 43, 50), 1'b0, 0, 7);

    chk("arr_bus_zero_when_idle", 128'(idle_viol), 128'(0));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
